// File: rtl/port_turnaround_ctrl.sv
// Half-duplex port sequencer: round-robin write/read grants, registered
// direction/data, and dead cycles on every direction change.
module port_turnaround_ctrl #(
  parameter int HI_INDEX     = 7,
  parameter int LO_INDEX     = 0,
  parameter int TURN_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int SAMPLE_DELAY = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [HI_INDEX:LO_INDEX] wr_data,
  output logic                   wr_ready,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic [HI_INDEX:LO_INDEX] rd_data,
  output logic                   port_dir,
  output logic [HI_INDEX:LO_INDEX] port_data_out,
  input  logic [HI_INDEX:LO_INDEX] port_data_in,
  output logic                   busy
);

  localparam logic DIR_IN   = 1'b0;
  localparam logic DIR_OUT  = 1'b1;
  localparam logic LG_READ  = 1'b0;
  localparam logic LG_WRITE = 1'b1;

  localparam int M1 = (TURN_CYCLES > HOLD_CYCLES)
                      ? TURN_CYCLES : HOLD_CYCLES;
  localparam int MAXC = (M1 > SAMPLE_DELAY + 1)
                        ? M1 : SAMPLE_DELAY + 1;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    TURN_OUT,
    DRIVE,
    TURN_IN,
    SAMPLE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     last_q, last_d;
  logic [HI_INDEX:LO_INDEX] word_q, word_d;
  logic                     dir_q, dir_d;
  logic [HI_INDEX:LO_INDEX] dout_q, dout_d;
  logic [HI_INDEX:LO_INDEX] rdat_q;
  logic                     rval_q;

  logic cnt_zero;
  logic dec_pt;
  logic wr_win;
  logic rd_win;
  logic capture;

  assign cnt_zero = (cnt_q == '0);
  assign dec_pt   = (state_q == IDLE) ||
                    (state_q == DRIVE && cnt_zero);
  // Tie goes to whichever side was not granted last.
  assign wr_win   = dec_pt && wr_valid &&
                    (!rd_req || last_q == LG_READ);
  assign rd_win   = (state_q == IDLE) && rd_req && !wr_win;
  assign capture  = (state_q == SAMPLE) && cnt_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_win) begin
          state_d = TURN_OUT;
          cnt_d   = CW'(TURN_CYCLES - 1);
        end else if (rd_win) begin
          state_d = SAMPLE;
          cnt_d   = CW'(SAMPLE_DELAY);
        end
      end
      TURN_OUT: begin
        if (cnt_zero) begin
          state_d = DRIVE;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRIVE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (wr_win) begin
          cnt_d = CW'(HOLD_CYCLES - 1);
        end else begin
          state_d = TURN_IN;
          cnt_d   = CW'(TURN_CYCLES - 1);
        end
      end
      TURN_IN, SAMPLE: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (wr_win) begin
      last_d = LG_WRITE;
    end else if (rd_win) begin
      last_d = LG_READ;
    end
    word_d = wr_win ? wr_data : word_q;
    dir_d  = (state_d == TURN_OUT || state_d == DRIVE)
             ? DIR_OUT : DIR_IN;
    dout_d = (dir_d == DIR_OUT) ? word_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LG_READ;
      word_q  <= '0;
      dir_q   <= DIR_IN;
      dout_q  <= '0;
      rdat_q  <= '0;
      rval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      rval_q  <= capture;
      if (capture) begin
        rdat_q <= port_data_in;
      end
    end
  end

  assign wr_ready      = wr_win;
  assign rd_valid      = rval_q;
  assign rd_data       = rdat_q;
  assign port_dir      = dir_q;
  assign port_data_out = dout_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_port_turnaround_ctrl.sv
// Directed bench for port_turnaround_ctrl (TURN=2, HOLD=1, SAMPLE_DELAY=0).
module tb_port_turnaround_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       port_dir;
  logic [7:0] port_data_out;
  logic [7:0] port_data_in;
  logic       busy;

  int tests = 0;
  int fails = 0;

  port_turnaround_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_req        (rd_req),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .port_dir      (port_dir),
    .port_data_out (port_data_out),
    .port_data_in  (port_data_in),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // dir/data/busy/wr_ready/rd_valid in one call
  task automatic st(input string tag, input logic d, input logic [7:0] o,
                    input logic b, input logic wr, input logic rv);
    chk({tag, ".dir"}, {7'b0, port_dir}, {7'b0, d});
    chk({tag, ".dout"}, port_data_out, o);
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    chk({tag, ".wrdy"}, {7'b0, wr_ready}, {7'b0, wr});
    chk({tag, ".rval"}, {7'b0, rd_valid}, {7'b0, rv});
  endtask

  initial begin
    reset_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    rd_req = 1'b0;
    port_data_in = 8'h00;
    nxt();
    nxt();
    st("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst.rdata", rd_data, 8'h00);
    reset_n = 1'b1;

    // 1: single write
    nxt(); wr_valid = 1'b1; wr_data = 8'hA5; #1;
    st("w1.T", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    nxt(); wr_valid = 1'b0; wr_data = 8'hFF; #1;
    st("w1.T1", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("w1.T2", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("w1.T3", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("w1.T4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("w1.T5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("w1.T6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: single read
    nxt(); rd_req = 1'b1; port_data_in = 8'h3C; #1;
    st("r2.T", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); rd_req = 1'b0; #1;
    st("r2.T1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); port_data_in = 8'h55; #1;
    st("r2.T2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("r2.T2.rdata", rd_data, 8'h3C);
    nxt(); #1;
    st("r2.T3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("r2.T3.rdata", rd_data, 8'h3C);

    // 3: back-to-back writes
    nxt(); wr_valid = 1'b1; wr_data = 8'h11; #1;
    st("b3.T", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    nxt(); wr_data = 8'h22; #1;
    st("b3.T1", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("b3.T2", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("b3.T3", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
    nxt(); wr_valid = 1'b0; #1;
    st("b3.T4", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("b3.T5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("b3.T6", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("b3.T7", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 4: contention from reset, grants alternate
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
    nxt(); rd_req = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    port_data_in = 8'h9A; #1;
    st("c4.T", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    nxt(); nxt(); nxt(); #1;
    st("c4.T3", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("c4.T4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("c4.T5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("c4.T6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); #1;
    st("c4.T7", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("c4.T8", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("c4.T8.rdata", rd_data, 8'h9A);
    nxt(); rd_req = 1'b0; wr_valid = 1'b0; #1;
    st("c4.T9", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);

    // 5: reset mid-DRIVE
    nxt(); nxt(); #1;
    st("r5.drive", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    nxt(); reset_n = 1'b0; #1;
    st("r5.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); reset_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      st("r5.post", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // 6: write then immediate read
    nxt(); wr_valid = 1'b1; wr_data = 8'hC3; #1;
    st("x6.T", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    nxt(); wr_valid = 1'b0; rd_req = 1'b1; port_data_in = 8'hE1; #1;
    st("x6.T1", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    nxt(); nxt(); #1;
    st("x6.T3", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("x6.T4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("x6.T5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("x6.T6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); rd_req = 1'b0; #1;
    st("x6.T7", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nxt(); #1;
    st("x6.T8", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("x6.T8.rdata", rd_data, 8'hE1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
